id_alu_op_stage: RTL and testbench
==================================

# id_alu_op_stage

Registered, back-pressured successor to the combinational ALU-op decoder in the ID stage. It decodes the full RV32I arithmetic, immediate, branch and jump space into an extended ALU-op code, and adds invert/illegal flags. Results pass through a 2-entry skid buffer so both ready paths are registered. It sits between the fetch/ID register and the EX-stage issue register, and honours EX flush.

## Interface
- `ALU_OP_W`, default 5: width of `out_alu_op`. Must be ≥4, or ≥5 when `ID_ALU_MEXT_EN` is defined. Codes are zero-extended.
- `TAG_W`, default 5: width of the opaque passthrough tag (e.g. rd index).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  EX flush; synchronous; highest priority
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept; registered
- `in_opcode`  in  7  instr[6:0]
- `in_func3`  in  3  instr[14:12]
- `in_func7`  in  7  instr[31:25]
- `in_tag`  in  TAG_W  passthrough
- `out_valid`  out  1  decoded entry valid
- `out_ready`  in  1  downstream accepts
- `out_alu_op`  out  ALU_OP_W  decoded op
- `out_br_inv`  out  1  invert branch condition (BNE/BGE/BGEU)
- `out_illegal`  out  1  unsupported encoding
- `out_tag`  out  TAG_W  passthrough

## Operation
- Op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, LT 5, JUMP 6, SLL 7, SRL 8, NOPE 9, SRA 10, LTU 11, PASS_B 12. Codes 0–9 keep their legacy values.
- OP (0110011): func3 000 → ADD, or SUB when func7=0100000. 001 SLL, 010 LT, 011 LTU, 100 XOR, 101 → SRL, or SRA when func7=0100000. 110 OR, 111 AND. func7 other than 0000000/0100000 → illegal.
- OP-IMM (0010011): same func3 map, but never SUB. 101 uses func7 for SRA; SLLI/SRLI/SRAI with a bad func7 → illegal.
- BRANCH (1100011): BEQ/BNE → SUB; BLT/BGE → LT; BLTU/BGEU → LTU. `out_br_inv`=1 for BNE/BGE/BGEU. func3 010/011 → illegal.
- JAL (1101111), JALR (1100111 with func3=000) → JUMP. LOAD, STORE, AUIPC → ADD. LUI → PASS_B.
- Any other opcode → illegal.
- Illegal entries still flow through with `out_alu_op`=NOPE and `out_illegal`=1.
- Skid buffer:
  - Main register M plus skid register S.
  - An accepted input goes to M if M is empty or draining this cycle; otherwise it goes to S.
  - S moves to M when M drains. Order is preserved.
  - `in_ready` next cycle = !S_valid_next.
- Flush, same cycle as any other activity:
  - Clears M and S valid bits.
  - Any input handshake that cycle is discarded.
  - `in_ready`=1 next cycle.
- Whenever `out_valid`=0: `out_alu_op`=NOPE; `out_br_inv`, `out_illegal` and `out_tag` are 0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_alu_op`=NOPE, `out_br_inv`=0, `out_illegal`=0, `out_tag`=0.
- Reset asserted mid-transfer drops all entries immediately, asynchronously.
- Latency: input accepted at edge N → `out_valid` after edge N (visible in cycle N+1) when M is empty.
- Throughput: 1 entry/cycle while `out_ready`=1.
- Full: with S valid, `in_ready`=0. The stage needs 2 stall cycles to fill.
- Simultaneous drain and accept with M full, S empty: M is loaded with the new entry; S stays empty.
- Simultaneous drain with S full: S→M; `in_ready` rises the next cycle.
- No combinational path from `out_ready` to `in_ready`, or from `in_*` to `out_*`.

## Configuration
- `ID_ALU_MEXT_EN` defined: OP with func7=0000001 decodes to MUL 13, MULH 14, MULHSU 15, MULHU 16, DIV 17, DIVU 18, REM 19, REMU 20, by func3 000–111.
- `ID_ALU_MEXT_EN` undefined: func7=0000001 → illegal/NOPE.
- An elaboration check fails if `ALU_OP_W`<5 with the macro defined.

## Structure
- Package `id_alu_pkg`: opcode, func3 and func7 constants; ALU op code constants; `ALU_OP_NOPE`.
- Sub-module `id_alu_op_decode`: purely combinational decode of (opcode, func3, func7) → {alu_op, br_inv, illegal}.
- The top level holds the skid buffer and flush logic.

## Test plan
- After reset: `in_ready`=1, `out_valid`=0, `out_alu_op`=9. Then send SUB (opcode 0110011, func3 000, func7 0100000, tag 3) with `out_ready`=1 → next cycle `out_alu_op`=1, `out_tag`=3.
- Sweep the full opcode/func3/func7 space → compare against a reference model. Includes BGEU → 11 with `br_inv`=1; LUI → 12; SRAI → 10; opcode 0001111 → 9 with illegal=1.
- `out_ready`=0 while streaming 3 instructions → 2 accepted, `in_ready`=0 after the second. Release → all 3 emerge in order, one per cycle.
- `flush` with M and S full, `in_valid`=1 the same cycle → next cycle `out_valid`=0, `in_ready`=1; the flushed-cycle input never appears.
- Assert `rst` asynchronously mid-stream with S full → outputs take reset values before the next edge.
- MUL (func7 0000001, func3 000): with `ID_ALU_MEXT_EN` → 13; without it → 9 with illegal=1.

Source files
------------

// File: rtl/id_alu_pkg.sv
// Shared encodings for the ID-stage ALU-op decoder: RV32I opcode/func fields and ALU op codes.
// Codes 13..20 are only produced when ID_ALU_MEXT_EN is defined.
package id_alu_pkg;

    typedef logic [4:0] alu_code_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    localparam alu_code_t ALU_OP_ADD    = 5'd0;
    localparam alu_code_t ALU_OP_SUB    = 5'd1;
    localparam alu_code_t ALU_OP_AND    = 5'd2;
    localparam alu_code_t ALU_OP_OR     = 5'd3;
    localparam alu_code_t ALU_OP_XOR    = 5'd4;
    localparam alu_code_t ALU_OP_LT     = 5'd5;
    localparam alu_code_t ALU_OP_JUMP   = 5'd6;
    localparam alu_code_t ALU_OP_SLL    = 5'd7;
    localparam alu_code_t ALU_OP_SRL    = 5'd8;
    localparam alu_code_t ALU_OP_NOPE   = 5'd9;
    localparam alu_code_t ALU_OP_SRA    = 5'd10;
    localparam alu_code_t ALU_OP_LTU    = 5'd11;
    localparam alu_code_t ALU_OP_PASS_B = 5'd12;
    localparam alu_code_t ALU_OP_MUL    = 5'd13;
    localparam alu_code_t ALU_OP_MULH   = 5'd14;
    localparam alu_code_t ALU_OP_MULHSU = 5'd15;
    localparam alu_code_t ALU_OP_MULHU  = 5'd16;
    localparam alu_code_t ALU_OP_DIV    = 5'd17;
    localparam alu_code_t ALU_OP_DIVU   = 5'd18;
    localparam alu_code_t ALU_OP_REM    = 5'd19;
    localparam alu_code_t ALU_OP_REMU   = 5'd20;

    // func3 map shared by OP and OP-IMM before the func7 variants are applied.
    function automatic alu_code_t alu_base_op(input logic [2:0] func3);
        alu_code_t op;
        case (func3)
            F3_ADD_SUB: op = ALU_OP_ADD;
            F3_SLL:     op = ALU_OP_SLL;
            F3_SLT:     op = ALU_OP_LT;
            F3_SLTU:    op = ALU_OP_LTU;
            F3_XOR:     op = ALU_OP_XOR;
            F3_SR:      op = ALU_OP_SRL;
            F3_OR:      op = ALU_OP_OR;
            default:    op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_alu_op_decode.sv
// Combinational RV32I decode of (opcode, func3, func7) into ALU op, branch-invert and illegal flags.
// ID_ALU_MEXT_EN enables the M-extension codes for OP with func7=0000001.
module id_alu_op_decode
    import id_alu_pkg::*;
#(
    parameter int ALU_OP_W = 5
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          func3,
    input  logic [6:0]          func7,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                br_inv,
    output logic                illegal
);

    alu_code_t code;
    logic      inv;
    logic      ill;

    always_comb begin
        code = ALU_OP_ADD;
        inv  = 1'b0;
        ill  = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (func7 == F7_MEXT) begin
`ifdef ID_ALU_MEXT_EN
                    code = ALU_OP_MUL + alu_code_t'(func3);
`else
                    ill = 1'b1;
`endif
                end else if (func7 == F7_BASE || func7 == F7_ALT) begin
                    code = alu_base_op(func3);
                    if (func7 == F7_ALT && func3 == F3_ADD_SUB) code = ALU_OP_SUB;
                    if (func7 == F7_ALT && func3 == F3_SR)      code = ALU_OP_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Only the shift immediates carry func7; other func3 values use those bits as imm.
                code = alu_base_op(func3);
                if (func3 == F3_SLL && func7 != F7_BASE) ill = 1'b1;
                if (func3 == F3_SR) begin
                    if (func7 == F7_ALT)       code = ALU_OP_SRA;
                    else if (func7 != F7_BASE) ill = 1'b1;
                end
            end
            OPC_BRANCH: begin
                case (func3)
                    F3_BEQ:  code = ALU_OP_SUB;
                    F3_BNE:  begin code = ALU_OP_SUB; inv = 1'b1; end
                    F3_BLT:  code = ALU_OP_LT;
                    F3_BGE:  begin code = ALU_OP_LT;  inv = 1'b1; end
                    F3_BLTU: code = ALU_OP_LTU;
                    F3_BGEU: begin code = ALU_OP_LTU; inv = 1'b1; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_JAL:  code = ALU_OP_JUMP;
            OPC_JALR: begin
                if (func3 == F3_JALR) code = ALU_OP_JUMP;
                else                  ill = 1'b1;
            end
            OPC_LOAD, OPC_STORE, OPC_AUIPC: code = ALU_OP_ADD;
            OPC_LUI:  code = ALU_OP_PASS_B;
            default:  ill = 1'b1;
        endcase
        if (ill) begin
            code = ALU_OP_NOPE;
            inv  = 1'b0;
        end
    end

    assign alu_op  = ALU_OP_W'(code);
    assign br_inv  = inv;
    assign illegal = ill;

endmodule

// File: rtl/id_alu_op_stage.sv
// Registered ID-stage ALU-op decoder with a 2-entry skid buffer (main M, skid S) and EX flush.
// ID_ALU_MEXT_EN enables M-extension decode and requires ALU_OP_W >= 5.
module id_alu_op_stage
    import id_alu_pkg::*;
#(
    parameter int ALU_OP_W = 5,
    parameter int TAG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_opcode,
    input  logic [2:0]          in_func3,
    input  logic [6:0]          in_func7,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_br_inv,
    output logic                out_illegal,
    output logic [TAG_W-1:0]    out_tag
);

    if (ALU_OP_W < 4) begin : g_width_chk
        $error("id_alu_op_stage: ALU_OP_W must be at least 4");
    end
`ifdef ID_ALU_MEXT_EN
    if (ALU_OP_W < 5) begin : g_mext_width_chk
        $error("id_alu_op_stage: ALU_OP_W must be at least 5 with ID_ALU_MEXT_EN");
    end
`endif

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                br_inv;
        logic                illegal;
        logic [TAG_W-1:0]    tag;
    } entry_t;

    entry_t              in_ent;
    logic [ALU_OP_W-1:0] dec_op;
    logic                dec_inv;
    logic                dec_ill;

    entry_t m_q, m_d, s_q, s_d;
    logic   m_valid_q, m_valid_d;
    logic   s_valid_q, s_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    id_alu_op_decode #(
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .opcode  (in_opcode),
        .func3   (in_func3),
        .func7   (in_func7),
        .alu_op  (dec_op),
        .br_inv  (dec_inv),
        .illegal (dec_ill)
    );

    assign in_ent = '{alu_op: dec_op, br_inv: dec_inv, illegal: dec_ill, tag: in_tag};

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // flush that cycle cancels the input transfer and empties the stage.
    assign accept = in_valid && in_ready_q && !flush;
    assign drain  = m_valid_q && out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            if (drain) m_valid_d = 1'b0;
            // in_ready_q is low whenever S holds data, so accept and S refill never coincide.
            if (s_valid_q) begin
                if (drain) begin
                    m_d       = s_q;
                    m_valid_d = 1'b1;
                    s_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (!m_valid_q || drain) begin
                    m_d       = in_ent;
                    m_valid_d = 1'b1;
                end else begin
                    s_d       = in_ent;
                    s_valid_d = 1'b1;
                end
            end
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_alu_op  = m_valid_q ? m_q.alu_op : ALU_OP_W'(ALU_OP_NOPE);
    assign out_br_inv  = m_valid_q && m_q.br_inv;
    assign out_illegal = m_valid_q && m_q.illegal;
    assign out_tag     = m_valid_q ? m_q.tag : '0;

endmodule

// File: tb/tb_id_alu_op_stage.sv
// Self-checking bench for id_alu_op_stage: reference decode model, expected-queue scoreboard,
// directed backpressure, flush and asynchronous-reset scenarios.
module tb_id_alu_op_stage;

    localparam int ALU_OP_W = 5;
    localparam int TAG_W    = 5;
    localparam int EW       = ALU_OP_W + 2 + TAG_W;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [6:0]          in_opcode;
    logic [2:0]          in_func3;
    logic [6:0]          in_func7;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic                out_br_inv;
    logic                out_illegal;
    logic [TAG_W-1:0]    out_tag;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [EW-1:0]   exp_q[$];
    bit              rand_ready_en = 0;

    id_alu_op_stage #(
        .ALU_OP_W (ALU_OP_W),
        .TAG_W    (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_func3    (in_func3),
        .in_func7    (in_func7),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_op  (out_alu_op),
        .out_br_inv  (out_br_inv),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {code[4:0], br_inv, illegal}.
    function automatic logic [6:0] ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int   base [8];
        int   code;
        logic inv;
        logic ill;
        base = '{0, 7, 5, 11, 4, 8, 3, 2};
        code = 9;
        inv  = 1'b0;
        ill  = 1'b0;
        if (op == 7'h33) begin
            if (f7 == 7'h01) begin
`ifdef ID_ALU_MEXT_EN
                code = 13 + int'(f3);
`else
                ill = 1'b1;
`endif
            end else if (f7 == 7'h00) begin
                code = base[f3];
            end else if (f7 == 7'h20) begin
                code = (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 10 : base[f3];
            end else begin
                ill = 1'b1;
            end
        end else if (op == 7'h13) begin
            code = base[f3];
            if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
            if (f3 == 3'd5 && f7 == 7'h20) code = 10;
            if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'h00) ill = 1'b1;
        end else if (op == 7'h63) begin
            if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            code = (f3 < 3'd4) ? 1 : (f3 < 3'd6) ? 5 : 11;
            inv  = f3[0];
        end else if (op == 7'h6f) begin
            code = 6;
        end else if (op == 7'h67) begin
            if (f3 == 3'd0) code = 6;
            else            ill  = 1'b1;
        end else if (op == 7'h03 || op == 7'h23 || op == 7'h17) begin
            code = 0;
        end else if (op == 7'h37) begin
            code = 12;
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            code = 9;
            inv  = 1'b0;
        end
        return {5'(code), inv, ill};
    endfunction

    function automatic logic [EW-1:0] exp_entry(input logic [6:0] op, input logic [2:0] f3,
                                                input logic [6:0] f7, input logic [TAG_W-1:0] tag);
        logic [6:0] r;
        r = ref_dec(op, f3, f7);
        return {ALU_OP_W'(r[6:2]), r[1], r[0], tag};
    endfunction

    // ---------------- scoreboard monitor (samples on falling edge) ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                else check_eq("sb_out", 32'({out_alu_op, out_br_inv, out_illegal, out_tag}),
                              32'(exp_q.pop_front()));
            end
            if (!out_valid)
                check_eq("idle_out", 32'({out_alu_op, out_br_inv, out_illegal, out_tag}),
                         32'({ALU_OP_W'(9), 2'b00, TAG_W'(0)}));
            if (in_valid && in_ready && !flush)
                exp_q.push_back(exp_entry(in_opcode, in_func3, in_func7, in_tag));
        end
    end

    // Random downstream back-pressure, updated off the edge used by the driver tasks.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [TAG_W-1:0] tag);
        bit acc;
        int guard;
        guard     = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_func3  = f3;
        in_func7  = f7;
        in_tag    = tag;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) check_eq("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Pipeline must be empty and out_ready=1: the entry is visible right after the accepting edge.
    task automatic send_check(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [TAG_W-1:0] tag,
                              input int e_op, input bit e_inv, input bit e_ill);
        send(op, f3, f7, tag);
        check_eq({name, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({name, "_op"}, 32'(out_alu_op), 32'(e_op));
        check_eq({name, "_inv"}, 32'(out_br_inv), 32'(e_inv));
        check_eq({name, "_ill"}, 32'(out_illegal), 32'(e_ill));
        check_eq({name, "_tag"}, 32'(out_tag), 32'(tag));
    endtask

    task automatic fill_two(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
        out_ready = 1'b0;
        send(7'h33, 3'd7, 7'h00, t0);
        send(7'h13, 3'd6, 7'h55, t1);
        check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [6:0] opc_list [13];
    logic [6:0] f7_list  [4];

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_func3  = '0;
        in_func7  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        opc_list  = '{7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h17, 7'h37,
                      7'h0f, 7'h73, 7'h00, 7'h7f};
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_alu_op", 32'(out_alu_op), 32'd9);
        check_eq("rst_flags_tag", 32'({out_br_inv, out_illegal, out_tag}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        send_check("sub", 7'b0110011, 3'b000, 7'b0100000, 5'd3, 1, 1'b0, 1'b0);
        wait_drain();
        send_check("bgeu", 7'h63, 3'd7, 7'h00, 5'd4, 11, 1'b1, 1'b0);
        wait_drain();
        send_check("lui", 7'h37, 3'd2, 7'h3a, 5'd5, 12, 1'b0, 1'b0);
        wait_drain();
        send_check("srai", 7'h13, 3'd5, 7'h20, 5'd6, 10, 1'b0, 1'b0);
        wait_drain();
        send_check("fence", 7'h0f, 3'd0, 7'h00, 5'd7, 9, 1'b0, 1'b1);
        wait_drain();
`ifdef ID_ALU_MEXT_EN
        send_check("mul", 7'h33, 3'd0, 7'h01, 5'd8, 13, 1'b0, 1'b0);
`else
        send_check("mul", 7'h33, 3'd0, 7'h01, 5'd8, 9, 1'b0, 1'b1);
`endif
        wait_drain();

        // Decode sweep under random back-pressure.
        rand_ready_en = 1;
        for (int i = 0; i < 13; i++) begin
            f7_list = '{7'h00, 7'h20, 7'h01, 7'($urandom_range(0, 127))};
            for (int f3 = 0; f3 < 8; f3++)
                for (int k = 0; k < 4; k++)
                    send(opc_list[i], 3'(f3), f7_list[k], TAG_W'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 60; i++)
            send(7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                 7'($urandom_range(0, 127)), TAG_W'($urandom_range(0, 31)));
        rand_ready_en = 0;
        wait_drain();

        // Back-pressure: two accepted, third held, then one per cycle in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_opcode = 7'h33; in_func3 = 3'd0; in_func7 = 7'h00; in_tag = 5'd10;
        @(posedge clk); #1;
        check_eq("bp_a_valid", 32'(out_valid), 32'd1);
        check_eq("bp_a_in_ready", 32'(in_ready), 32'd1);
        in_opcode = 7'h13; in_func3 = 3'd4; in_func7 = 7'h11; in_tag = 5'd11;
        @(posedge clk); #1;
        check_eq("bp_full_in_ready", 32'(in_ready), 32'd0);
        in_opcode = 7'h33; in_func3 = 3'd5; in_func7 = 7'h20; in_tag = 5'd12;
        @(posedge clk); #1;
        check_eq("bp_hold_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_hold_tag", 32'(out_tag), 32'd10);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_b_tag", 32'(out_tag), 32'd11);
        check_eq("bp_b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_c_tag", 32'(out_tag), 32'd12);
        check_eq("bp_c_op", 32'(out_alu_op), 32'd10);
        @(posedge clk); #1;
        check_eq("bp_empty", 32'(out_valid), 32'd0);
        wait_drain();

        // Flush with M and S full and an input offered.
        fill_two(5'd20, 5'd21);
        in_valid = 1'b1; in_opcode = 7'h6f; in_tag = 5'd22;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("flush_no_ghost", 32'(out_valid), 32'd0);
        end

        // Flush with only M full while the stage is ready: the offered input is dropped.
        out_ready = 1'b0;
        send(7'h37, 3'd0, 7'h00, 5'd23);
        in_valid = 1'b1; in_opcode = 7'h6f; in_tag = 5'd24;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check_eq("flush2_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("flush2_no_ghost", 32'(out_valid), 32'd0);

        // Asynchronous reset with S full: outputs reset before the next edge.
        fill_two(5'd25, 5'd26);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_alu_op", 32'(out_alu_op), 32'd9);
        check_eq("arst_flags_tag", 32'({out_br_inv, out_illegal, out_tag}), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_check("post_rst", 7'h63, 3'd1, 7'h00, 5'd27, 1, 1'b1, 1'b0);

        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
